// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN             = 2'd0,
        DEBOUNCE_PRESS   = 2'd1,
        HELD             = 2'd2,
        DEBOUNCE_RELEASE = 2'd3
    } kp_state_t;

    // Column drive while column 0 is selected (one-cold).
    localparam logic [3:0] COLS_IDLE = 4'b1110;

    // Hex code for each key, indexed {row, col}.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // One-cold column drive for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Lowest-index row that reads low (closed); 0 when none are low.
    function automatic logic [1:0] first_low(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the 4 asynchronous keypad row lines.
// Latency: 2 clk cycles from input change to output.
// Backpressure: none; free-running.
module sync_2ff (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    // Both stages reset to 1 so an idle (pulled-up) keypad is the reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 keypad, debounces press/release, keeps the last two key codes.
// Latency: key_valid DEBOUNCE_CYCLES cycles after the capture dwell cycle.
// Backpressure: none; key_valid is a single-cycle pulse with no handshake.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 48000,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] digit_recent,
    output logic [3:0] digit_prev,
    output logic       key_held
);

    localparam int DW  = $clog2(SCAN_CYCLES + 1);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [DBW-1:0] DEB_DONE   = DBW'(DEBOUNCE_CYCLES);

    logic [3:0] rs;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rows),
        .q_o   (rs)
    );

    kp_state_t      state_q,     state_d;
    logic [1:0]     col_idx_q,   col_idx_d;
    logic [1:0]     row_idx_q,   row_idx_d;
    logic [3:0]     cols_q,      cols_d;
    logic [DW-1:0]  dwell_q,     dwell_d;
    logic [DBW-1:0] deb_q,       deb_d;
    logic           key_valid_q, key_valid_d;
    logic [3:0]     key_code_q,  key_code_d;
    logic [3:0]     recent_q,    recent_d;
    logic [3:0]     prev_q,      prev_d;
    logic           held_q,      held_d;

    logic           row_lvl;
    logic [DBW-1:0] deb_inc;
    logic [3:0]     code;

    assign row_lvl = rs[row_idx_q];
    assign deb_inc = deb_q + DBW'(1);
    assign code    = KEY_MAP[{row_idx_q, col_idx_q}];

    // Next-state: scan dwell, press/release debounce, digit shift on acceptance.
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        dwell_d     = dwell_q;
        deb_d       = deb_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        recent_d    = recent_q;
        prev_d      = prev_q;
        held_d      = held_q;

        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (rs != 4'hF) begin
                        // The capture cycle itself counts as the first stable-low cycle.
                        row_idx_d = first_low(rs);
                        deb_d     = DBW'(1);
                        state_d   = DEBOUNCE_PRESS;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            DEBOUNCE_PRESS: begin
                if (row_lvl) begin
                    state_d   = SCAN;
                    col_idx_d = col_idx_q + 2'd1;
                    dwell_d   = '0;
                    deb_d     = '0;
                end else begin
                    deb_d = deb_inc;
                    if (deb_inc == DEB_DONE) begin
                        state_d     = HELD;
                        key_valid_d = 1'b1;
                        key_code_d  = code;
                        prev_d      = recent_q;
                        recent_d    = code;
                        held_d      = 1'b1;
                        deb_d       = '0;
                    end
                end
            end
            HELD: begin
                if (row_lvl) begin
                    state_d = DEBOUNCE_RELEASE;
                    deb_d   = DBW'(1);
                end
            end
            DEBOUNCE_RELEASE: begin
                if (!row_lvl) begin
                    state_d = HELD;
                    deb_d   = '0;
                end else begin
                    deb_d = deb_inc;
                    if (deb_inc == DEB_DONE) begin
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                        dwell_d   = '0;
                        deb_d     = '0;
                        held_d    = 1'b0;
                    end
                end
            end
            default: state_d = SCAN;
        endcase

        cols_d = col_drive(col_idx_d);
    end

    // State and output registers; synchronous reset returns everything to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            cols_q      <= COLS_IDLE;
            dwell_q     <= '0;
            deb_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            recent_q    <= 4'h0;
            prev_q      <= 4'h0;
            held_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            cols_q      <= cols_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            recent_q    <= recent_d;
            prev_q      <= prev_d;
            held_q      <= held_d;
        end
    end

    assign cols         = cols_q;
    assign key_valid    = key_valid_q;
    assign key_code     = key_code_q;
    assign digit_recent = recent_q;
    assign digit_prev   = prev_q;
    assign key_held     = held_q;

endmodule
